// File: rtl/xyz_sampler_pkg.sv
// Shared types and defaults for the xyz_sampler block.
// A sample is the three upstream register bits packed as {z, y, x}.
package xyz_sampler_pkg;

  localparam int DEPTH_DEFAULT       = 4;
  localparam int CAPTURE_LEN_DEFAULT = 16;

  typedef struct packed {
    logic z;
    logic y;
    logic x;
  } sample_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/xyz_fifo.sv
// Small sample queue for xyz_sampler.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// Occupancy carries one extra bit so full and empty stay distinct.
// A push into a full queue is still taken when a pop happens in the same cycle.
module xyz_fifo
  import xyz_sampler_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic    i_clk,
  input  logic    i_arst,
  input  logic    i_clear,
  input  logic    i_push,
  input  sample_t i_data,
  input  logic    i_pop,
  output sample_t o_data,
  output logic    o_valid,
  output logic    o_full
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   OCC_ONE  = 1;
  localparam logic [AW:0]   FULL_OCC = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  sample_t       mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_pop  = i_pop && o_valid;
  assign do_push = i_push && (!o_full || do_pop);

  // Pointer and occupancy bookkeeping; clear wins over push and pop.
  always_ff @(posedge i_clk or negedge i_arst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!i_arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (i_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      occ <= occ + OCC_ONE;
      else if (do_pop && !do_push) occ <= occ - OCC_ONE;
    end
  end

  // Sample storage write port.
  always_ff @(posedge i_clk) begin
    // NOTE: the storage array is deliberately not reset; occupancy alone
    // decides what is valid, and the read side masks stale contents.
    if (do_push && !i_clear) mem[wr_ptr] <= i_data;
  end

  assign o_valid = (occ != '0);
  assign o_full  = (occ == FULL_OCC);
  assign o_data  = o_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/xyz_sampler.sv
// xyz_sampler: on request, samples {i_z, i_y, i_x} for CAPTURE_LEN cycles into
// a small queue, then waits for the consumer to drain it and pulses o_done.
// Optional build macro XYZ_SAMPLER_CHANGE_ONLY_EN: only the first sample of a
// window and samples differing from the previous pushed one are queued.
module xyz_sampler
  import xyz_sampler_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int CAPTURE_LEN = CAPTURE_LEN_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_arst,
  input  logic       i_srst,
  input  logic       i_start,
  input  logic       i_z,
  input  logic       i_y,
  input  logic       i_x,
  output logic [2:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_overflow,
  output logic [7:0] o_count
);

  // Encoding kept identical to state_t so waveforms decode with the enum.
  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_CAPTURE = CAPTURE;
  localparam logic [1:0] ST_DRAIN   = DRAIN;
  localparam logic [7:0] LEN        = 8'(CAPTURE_LEN);

  logic [1:0] state;
  logic [7:0] count_next;
  sample_t    sample;
  sample_t    fifo_data;
  logic       fifo_full;
  logic       in_capture;
  logic       push_req;
  logic       pop;
  logic       drop;

  assign sample     = {i_z, i_y, i_x};
  assign in_capture = (state == ST_CAPTURE);
  assign count_next = o_count + 8'd1;
  assign pop        = o_valid && i_ready;

`ifdef XYZ_SAMPLER_CHANGE_ONLY_EN
  sample_t last_sample;

  // Remembers the most recent sample offered to the queue.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst)       last_sample <= '0;
    else if (i_srst)   last_sample <= '0;
    else if (push_req) last_sample <= sample;
  end

  // A zero count marks the first capture cycle of the window.
  assign push_req = in_capture && ((o_count == 8'd0) || (sample != last_sample));
`else
  assign push_req = in_capture;
`endif

  // A push is lost only when the queue is full and nothing leaves this cycle.
  assign drop = push_req && fifo_full && !pop;

  xyz_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_arst  (i_arst),
    .i_clear (i_srst),
    .i_push  (push_req),
    .i_data  (sample),
    .i_pop   (pop),
    .o_data  (fifo_data),
    .o_valid (o_valid),
    .o_full  (fifo_full)
  );

  // Control FSM, window counter and sticky overflow flag.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state      <= ST_IDLE;
      o_count    <= '0;
      o_overflow <= 1'b0;
    end else if (i_srst) begin
      state      <= ST_IDLE;
      o_count    <= '0;
      o_overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state      <= ST_CAPTURE;
            o_count    <= '0;
            o_overflow <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          // Leaving on the edge the count reaches LEN makes it saturate there.
          o_count <= count_next;
          if (count_next == LEN) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!o_valid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (drop) o_overflow <= 1'b1;
    end
  end

  assign o_data = fifo_data;
  assign o_busy = (state != ST_IDLE);
  assign o_done = (state == ST_DRAIN) && !o_valid;

endmodule

// File: tb/tb_xyz_sampler.sv
// Self-checking bench for xyz_sampler. Three instances share clock, resets and
// sample inputs: CAPTURE_LEN 4, 6 and 8, all with DEPTH 4.
module tb_xyz_sampler;

  localparam int N = 3;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       arst;
  logic       srst;
  logic [2:0] xyz;
  logic       start [N];
  logic       ready [N];
  logic       valid [N];
  logic       busy  [N];
  logic       done  [N];
  logic       ovf   [N];
  logic [2:0] data  [N];
  logic [7:0] count [N];

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] seen [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    xyz_sampler #(
      .DEPTH       (DEPTH),
      .CAPTURE_LEN (4 + 2 * g)
    ) u_dut (
      .i_clk      (clk),
      .i_arst     (arst),
      .i_srst     (srst),
      .i_start    (start[g]),
      .i_z        (xyz[2]),
      .i_y        (xyz[1]),
      .i_x        (xyz[0]),
      .o_data     (data[g]),
      .o_valid    (valid[g]),
      .i_ready    (ready[g]),
      .o_busy     (busy[g]),
      .o_done     (done[g]),
      .o_overflow (ovf[g]),
      .o_count    (count[g])
    );
  end

  typedef struct {
    logic       start;
    logic       ready;
    logic [2:0] xyz;
    logic       valid;
    logic [2:0] data;
    logic       busy;
    logic       done;
    logic       ovf;
    logic [7:0] count;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] outs(input int i);
    return {valid[i], data[i], busy[i], done[i], ovf[i], count[i]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Collects every handed-over sample until o_done shows, then steps into IDLE.
  task automatic drain_collect(input int idx, input int max_cycles, output bit got_done);
    got_done = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      if (done[idx]) begin
        got_done = 1'b1;
        break;
      end
      if (valid[idx] && ready[idx]) seen.push_back(data[idx]);
      tick();
    end
    if (got_done) tick();
  endtask

  // ---------------- reference model for instance 2 (CAPTURE_LEN 8) --------
  localparam int M_LEN = 8;
  int         m_mode;   // 0 idle, 1 capturing, 2 waiting for drain
  int         m_cnt;
  bit         m_ovf;
  logic [2:0] m_last;
  logic [2:0] m_q [$];

  task automatic model_reset();
    m_mode = 0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_last = '0;
    m_q.delete();
  endtask

  // Advances the model by one clock edge using the inputs in force before it.
  task automatic model_step();
    bit pop;
    bit full;
    bit want;
    pop  = (m_q.size() > 0) && ready[2];
    full = (m_q.size() == DEPTH);
    want = 1'b0;
    if (srst) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: if (start[2]) begin
        m_mode = 1;
        m_cnt  = 0;
        m_ovf  = 1'b0;
      end
      1: begin
`ifdef XYZ_SAMPLER_CHANGE_ONLY_EN
        want = (m_cnt == 0) || (xyz != m_last);
        if (want) m_last = xyz;
`else
        want = 1'b1;
`endif
        m_cnt++;
        if (m_cnt == M_LEN) m_mode = 2;
      end
      default: if (m_q.size() == 0) m_mode = 0;
    endcase
    if (pop) void'(m_q.pop_front());
    if (want) begin
      if (!full || pop) m_q.push_back(xyz);
      else m_ovf = 1'b1;
    end
  endtask

  function automatic logic [14:0] model_outs();
    logic       v;
    logic [2:0] d;
    v = (m_q.size() > 0);
    d = v ? m_q[0] : 3'b000;
    return {v, d, 1'(m_mode != 0), 1'(m_mode == 2 && !v), m_ovf, 8'(m_cnt)};
  endfunction

  // Timeout guard so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [7];
    logic [2:0] seq [8];
    bit         got;
    int         hits;

    arst = 1'b0;
    srst = 1'b0;
    xyz  = '0;
    for (int i = 0; i < N; i++) begin
      start[i] = 1'b0;
      ready[i] = 1'b0;
    end
    #12;
    for (int i = 0; i < N; i++) check($sformatf("reset_state_%0d", i), outs(i), 15'd0);
    @(negedge clk);
    arst = 1'b1;
    tick();

    // ---- basic window, CAPTURE_LEN 4, constant 101, consumer always ready
    //          start ready xyz      valid data     busy done ovf count
    tbl[0] = '{1'b1, 1'b1, 3'b101, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{1'b0, 1'b1, 3'b101, 1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 8'd1};
`ifdef XYZ_SAMPLER_CHANGE_ONLY_EN
    tbl[2] = '{1'b0, 1'b1, 3'b101, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 8'd2};
    tbl[3] = '{1'b0, 1'b1, 3'b101, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 8'd3};
    tbl[4] = '{1'b0, 1'b1, 3'b101, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 8'd4};
    tbl[5] = '{1'b0, 1'b1, 3'b101, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'd4};
    tbl[6] = '{1'b0, 1'b1, 3'b101, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'd4};
`else
    tbl[2] = '{1'b0, 1'b1, 3'b101, 1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 8'd2};
    tbl[3] = '{1'b0, 1'b1, 3'b101, 1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 8'd3};
    tbl[4] = '{1'b0, 1'b1, 3'b101, 1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 8'd4};
    tbl[5] = '{1'b0, 1'b1, 3'b101, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 8'd4};
    tbl[6] = '{1'b0, 1'b1, 3'b101, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'd4};
`endif
    for (int r = 0; r < 7; r++) begin
      start[0] = tbl[r].start;
      ready[0] = tbl[r].ready;
      xyz      = tbl[r].xyz;
      tick();
      check($sformatf("basic_row%0d", r), outs(0),
            {tbl[r].valid, tbl[r].data, tbl[r].busy, tbl[r].done, tbl[r].ovf, tbl[r].count});
    end
    start[0] = 1'b0;

    // ---- overflow: CAPTURE_LEN 6, consumer stalled, then released
    ready[1] = 1'b0;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      xyz = 3'(k);
      tick();
      check($sformatf("ovf_count_%0d", k), count[1], k);
      check($sformatf("ovf_flag_%0d", k), ovf[1], (k >= 5) ? 1 : 0);
    end
    check("ovf_head", {valid[1], data[1], busy[1]}, {1'b1, 3'd1, 1'b1});
    for (int s = 0; s < 2; s++) begin
      tick();
      check($sformatf("stall_hold_%0d", s), {valid[1], data[1]}, {1'b1, 3'd1});
    end
    ready[1] = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      check($sformatf("ovf_drain_%0d", j), {valid[1], data[1]}, {1'b1, 3'(j)});
      tick();
    end
    check("ovf_drain_done", {valid[1], done[1], ovf[1]}, 3'b011);
    tick();
    check("ovf_sticky_idle", {busy[1], ovf[1]}, 2'b01);
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    check("ovf_cleared_by_start", {busy[1], ovf[1], count[1]}, {1'b1, 1'b0, 8'd0});
    seen.delete();
    drain_collect(1, 30, got);
    check("ovf_restart_done", got, 1);

    // ---- full queue with a pop on the push cycle
    seen.delete();
    ready[1] = 1'b0;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      xyz = 3'(k);
      tick();
    end
    ready[1] = 1'b1;
    for (int k = 5; k <= 6; k++) begin
      xyz = 3'(k);
      if (valid[1] && ready[1]) seen.push_back(data[1]);
      tick();
      check($sformatf("full_pushpop_ovf_%0d", k), ovf[1], 0);
    end
    drain_collect(1, 20, got);
    check("full_pushpop_done", got, 1);
    check("full_pushpop_n", seen.size(), 6);
    for (int i = 0; i < seen.size(); i++)
      check($sformatf("full_pushpop_data_%0d", i), seen[i], i + 1);

    // ---- synchronous clear mid-drain, and its priority over i_start
    ready[1] = 1'b0;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      xyz = 3'(k);
      tick();
    end
    srst = 1'b1;
    start[1] = 1'b1;
    tick();
    check("srst_clear", outs(1), 15'd0);
    tick();
    check("srst_over_start", busy[1], 0);
    srst = 1'b0;
    start[1] = 1'b0;
    hits = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done[1]) hits++;
    end
    check("srst_no_done", hits, 0);

    // ---- asynchronous reset mid-capture
    ready[0] = 1'b1;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    xyz = 3'd1;
    tick();
    xyz = 3'd2;
    tick();
    check("arst_pre_count", count[0], 2);
    #2;
    arst = 1'b0;
    #1;
    check("arst_async", outs(0), 15'd0);
    @(negedge clk);
    arst = 1'b1;
    hits = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done[0]) hits++;
    end
    check("arst_no_done", {hits[7:0], busy[0]}, 9'd0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    check("arst_restart_0", {busy[0], count[0]}, {1'b1, 8'd0});
    xyz = 3'd3;
    tick();
    check("arst_restart_1", count[0], 1);
    drain_collect(0, 20, got);
    check("arst_restart_done", got, 1);

    // ---- change-only window, CAPTURE_LEN 8
    seq = '{3'b000, 3'b000, 3'b011, 3'b011, 3'b011, 3'b100, 3'b100, 3'b100};
    seen.delete();
    ready[2] = 1'b1;
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      xyz = seq[k];
      if (valid[2] && ready[2]) seen.push_back(data[2]);
      tick();
    end
    drain_collect(2, 20, got);
    check("chg_done", got, 1);
    check("chg_count", {count[2], ovf[2]}, {8'd8, 1'b0});
`ifdef XYZ_SAMPLER_CHANGE_ONLY_EN
    check("chg_n", seen.size(), 3);
    if (seen.size() == 3) begin
      check("chg_s0", seen[0], 3'b000);
      check("chg_s1", seen[1], 3'b011);
      check("chg_s2", seen[2], 3'b100);
    end
`else
    check("chg_n", seen.size(), 8);
    for (int i = 0; i < seen.size(); i++)
      check($sformatf("chg_s%0d", i), seen[i], seq[i]);
`endif

    // ---- i_start held high across the whole window
    ready[0] = 1'b1;
    start[0] = 1'b1;
    tick();
    check("hold_t0", {busy[0], count[0]}, {1'b1, 8'd0});
    for (int t = 1; t <= 4; t++) begin
      xyz = 3'(t);
      tick();
      check($sformatf("hold_t%0d", t), {busy[0], count[0]}, {1'b1, 8'(t)});
    end
    tick();
    check("hold_done", {busy[0], done[0]}, 2'b11);
    tick();
    check("hold_idle", {busy[0], done[0]}, 2'b00);
    tick();
    check("hold_restart", {busy[0], count[0]}, {1'b1, 8'd0});
    start[0] = 1'b0;
    drain_collect(0, 20, got);
    check("hold_restart_done", got, 1);

    // ---- randomized traffic on instance 2 against the reference model
    srst = 1'b1;
    tick();
    srst = 1'b0;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      start[2] = ($urandom_range(0, 9) == 0);
      ready[2] = ($urandom_range(0, 99) < 60);
      srst     = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 1) == 1) xyz = 3'($urandom_range(0, 7));
      model_step();
      tick();
      check($sformatf("rand_cyc%0d", c), outs(2), model_outs());
    end
    srst = 1'b0;
    start[2] = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xyz_sampler.md
XYZ_SAMPLER -- requirements
Module: xyz_sampler

Interface
REQ-001 Parameters SHALL be, one per line:
- DEPTH, default 4: FIFO entries, power of two, 2..16.
- CAPTURE_LEN, default 16: capture window in cycles, 1..255.

REQ-002 Ports SHALL be, one per line:
- i_clk, input, 1: sole clock, rising edge.
- i_arst, input, 1: asynchronous, active-low reset.
- i_srst, input, 1: synchronous clear, active-high.
- i_start, input, 1: capture request.
- i_z / i_y / i_x, input, 1 each: upstream register outputs being sampled.
- o_data, output, 3: oldest queued sample {z,y,x}.
- o_valid, output, 1: o_data holds a sample.
- i_ready, input, 1: consumer accepts o_data.
- o_busy, output, 1: FSM not in IDLE.
- o_done, output, 1: one-cycle completion pulse.
- o_overflow, output, 1: sticky flag, sample dropped.
- o_count, output, 8: cycles sampled in current or last window.

Function
REQ-003 FSM states SHALL be IDLE, CAPTURE, DRAIN; o_busy = (state != IDLE).
REQ-004 IDLE -> CAPTURE SHALL occur on i_start=1; the same edge clears o_count and o_overflow.
REQ-005 Each CAPTURE cycle SHALL sample {i_z,i_y,i_x}, increment o_count and push the sample.
REQ-006 CAPTURE -> DRAIN SHALL occur on the edge where o_count becomes CAPTURE_LEN.
REQ-007 DRAIN -> IDLE SHALL occur on the first cycle the FIFO is empty, with o_done=1 for exactly that cycle.
REQ-008 i_start SHALL be ignored in CAPTURE and DRAIN.
REQ-009 A sample pushed at edge k SHALL appear on o_data with o_valid=1 after edge k (one-cycle latency), with no combinational path from i_z/i_y/i_x to o_data.
REQ-010 A pop SHALL occur when o_valid && i_ready; o_data and o_valid SHALL stay stable while o_valid && !i_ready.
REQ-011 When full, a push SHALL be accepted if a pop occurs in the same cycle; otherwise the sample is dropped and o_overflow is set.
REQ-012 o_overflow SHALL remain set until the next accepted i_start, i_srst or reset.
REQ-013 Push and pop on an empty FIFO SHALL leave the FIFO empty-to-one-entry consistent: the pushed sample is queued and nothing is popped.
REQ-014 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL use one extra bit so full and empty are distinguishable.
REQ-015 o_count SHALL saturate at CAPTURE_LEN and hold its value in DRAIN and IDLE.

Reset
REQ-016 i_arst=0 SHALL asynchronously force: state IDLE, FIFO empty, o_valid=0, o_data=0, o_done=0, o_overflow=0, o_count=0, o_busy=0.
REQ-017 i_srst=1 SHALL apply the same values synchronously and take priority over i_start, push and pop.
REQ-018 Reset in mid-capture or mid-drain SHALL discard all queued samples; no o_done pulse is produced.

Configuration
REQ-019 With XYZ_SAMPLER_CHANGE_ONLY_EN defined, CAPTURE SHALL push only the first sample of a window and any sample differing from the last pushed sample; o_count still counts every capture cycle.
REQ-020 Without XYZ_SAMPLER_CHANGE_ONLY_EN, every CAPTURE cycle SHALL push; no last-sample register exists.

Structure
REQ-021 Package xyz_sampler_pkg SHALL hold:
- sample_t (3-bit packed struct z,y,x);
- state_t enum;
- DEPTH_DEFAULT and CAPTURE_LEN_DEFAULT constants.
REQ-022 Queue storage SHALL be one sub-module, xyz_fifo (DEPTH-parameterised, async active-low reset, sync clear).

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- CAPTURE_LEN=4, i_ready=1, inputs 3'b101 constant, i_start pulse -> four samples 3'b101 on consecutive cycles; o_count=4; o_done one cycle after the last pop; o_overflow=0.
- DEPTH=4, CAPTURE_LEN=6, i_ready=0 -> four entries queued; o_overflow=1 from the fifth capture cycle; releasing i_ready drains exactly 4 samples, then o_done.
- FIFO full with i_ready=1 on a push cycle -> push accepted; o_overflow stays 0.
- i_arst=0 asserted mid-CAPTURE (o_count=2) -> all outputs 0 immediately; no o_done afterwards; next i_start restarts with o_count counting from 1.
- XYZ_SAMPLER_CHANGE_ONLY_EN, CAPTURE_LEN=8, inputs 000,000,011,011,011,100,100,100 -> exactly 000, 011, 100 emitted; o_count=8.
- i_start held high during DRAIN -> no restart; IDLE reached, then a new capture on the next cycle i_start is high.
